// File: rtl/slice_detransposer.sv
// Collects NUM_SLICES masked, redundant bitsliced inputs, strips redundancy and
// unmasks each one, then drains 32 transposed words. Optional macro SLICE_DETRANSPOSER_UNROTATE_EN.
module slice_detransposer #(
    parameter int NUM_SLICES = 32
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] slice_i,
    input  logic        slice_valid_i,
    output logic        slice_ready_o,
    input  logic [1:0]  D_i,
    input  logic [1:0]  R_s_i,
    input  logic        comp_redund_i,
    input  logic        abort_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        redundancy_error_o,
    output logic        done_o
);
    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
    localparam logic [4:0] LAST_SLICE = 5'(NUM_SLICES - 1);

    state_t                      state;
    logic [1:0]                  d_q, r_q;
    logic                        comp_q;
    logic [4:0]                  s_cnt, w_cnt;
    logic [NUM_SLICES-1:0][31:0] rows;

    logic        slice_xfer, word_xfer;
    logic [1:0]  d_eff, r_eff;
    logic        comp_eff;
    logic [4:0]  s_idx;
    logic [31:0] kept, unmasked, row_val, column;
    logic        mismatch;

    assign slice_xfer = slice_valid_i && slice_ready_o;
    assign word_xfer  = word_valid_o && word_ready_i;

    // The first slice of a block is decoded with the live config inputs.
    assign d_eff    = (state == IDLE) ? D_i : d_q;
    assign r_eff    = (state == IDLE) ? R_s_i : r_q;
    assign comp_eff = (state == IDLE) ? comp_redund_i : comp_q;
    assign s_idx    = (state == IDLE) ? 5'd0 : s_cnt;

    always_comb begin
        kept     = slice_i;
        mismatch = 1'b0;
        case (r_eff)
            2'd2: begin
                kept     = {24'd0, slice_i[7:0]};
                mismatch = ((slice_i[31:24] ^ {8{comp_eff}}) != slice_i[7:0]) ||
                           (slice_i[23:16] != slice_i[7:0]) ||
                           ((slice_i[15:8] ^ {8{comp_eff}}) != slice_i[7:0]);
            end
            2'd1: begin
                kept     = {16'd0, slice_i[15:0]};
                mismatch = (slice_i[31:16] ^ {16{comp_eff}}) != slice_i[15:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        unmasked = kept;
        case (d_eff)
            2'd2: begin
                unmasked = '0;
                for (int k = 0; k < 8; k++) unmasked[k] = ^kept[4*k +: 4];
            end
            2'd1: begin
                unmasked = '0;
                for (int k = 0; k < 16; k++) unmasked[k] = kept[2*k+1] ^ kept[2*k];
            end
            default: ;
        endcase
    end

`ifdef SLICE_DETRANSPOSER_UNROTATE_EN
    logic [63:0] rot_ext;
    // Upper half of the doubled word shifted left is a left rotation.
    always_comb begin
        rot_ext = {unmasked, unmasked} << s_idx;
        row_val = s_idx[0] ? unmasked : rot_ext[63:32];
    end
`else
    assign row_val = unmasked;
`endif

    always_comb begin
        column = '0;
        for (int i = 0; i < NUM_SLICES; i++) column[i] = rows[i][w_cnt];
    end
    assign word_o = word_valid_o ? column : 32'd0;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state              <= IDLE;
            d_q                <= '0;
            r_q                <= '0;
            comp_q             <= 1'b0;
            s_cnt              <= '0;
            w_cnt              <= '0;
            rows               <= '0;
            slice_ready_o      <= 1'b0;
            word_valid_o       <= 1'b0;
            redundancy_error_o <= 1'b0;
            done_o             <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (abort_i) begin
                state         <= IDLE;
                rows          <= '0;
                s_cnt         <= '0;
                w_cnt         <= '0;
                slice_ready_o <= 1'b1;
                word_valid_o  <= 1'b0;
            end else begin
                case (state)
                    IDLE, COLLECT: begin
                        slice_ready_o <= 1'b1;
                        if (slice_xfer) begin
                            for (int i = 0; i < NUM_SLICES; i++)
                                if (s_idx == 5'(i)) rows[i] <= row_val;
                            if (state == IDLE) begin
                                d_q                <= D_i;
                                r_q                <= R_s_i;
                                comp_q             <= comp_redund_i;
                                redundancy_error_o <= mismatch;
                            end else begin
                                redundancy_error_o <= redundancy_error_o | mismatch;
                            end
                            if (s_idx == LAST_SLICE) begin
                                state         <= DRAIN;
                                s_cnt         <= '0;
                                slice_ready_o <= 1'b0;
                                word_valid_o  <= 1'b1;
                            end else begin
                                state <= COLLECT;
                                s_cnt <= s_idx + 5'd1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (word_xfer) begin
                            if (w_cnt == 5'd31) begin
                                state         <= IDLE;
                                rows          <= '0;
                                w_cnt         <= '0;
                                done_o        <= 1'b1;
                                word_valid_o  <= 1'b0;
                                slice_ready_o <= 1'b1;
                            end else begin
                                w_cnt <= w_cnt + 5'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
